// File: rtl/sd_wb_block_dma.sv
// Block-transfer engine between the SD block-buffer BRAMs and Wishbone memory.
// One pending request per direction; incrementing bursts with range, timeout and stop handling.
module sd_wb_block_dma #(
  parameter int unsigned BLK_WORDS   = 128,
  parameter int unsigned BRAM_AW     = 7,
  parameter int unsigned BURST_LEN   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] CAP_BLOCKS  = 32'd127488,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic               clk_50,
  input  logic               reset_n,
  input  logic               rd_req,
  input  logic [31:0]        rd_blk,
  input  logic               rd_stop,
  output logic               rd_done,
  input  logic               wr_req,
  input  logic [31:0]        wr_blk,
  output logic               wr_done,
  output logic               busy,
  output logic               err_range,
  output logic               err_timeout,
  output logic [BRAM_AW-1:0] bram_rd_addr,
  output logic               bram_rd_wren,
  output logic [31:0]        bram_rd_data,
  output logic [BRAM_AW-1:0] bram_wr_addr,
  input  logic [31:0]        bram_wr_q,
  output logic [31:0]        wbm_adr_o,
  input  logic [31:0]        wbm_dat_i,
  output logic [31:0]        wbm_dat_o,
  output logic [3:0]         wbm_sel_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  input  logic               wbm_ack_i,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o
);

  localparam int unsigned        TW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [BRAM_AW-1:0] BL_MASK = BRAM_AW'(BURST_LEN - 1);
  localparam logic [BRAM_AW-1:0] LAST_IX = BRAM_AW'(BLK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WR_PRIME, S_BURST, S_GAP, S_FINISH
  } state_t;

  state_t             state_q;
  logic               rd_pend_q, wr_pend_q, sel_wr_q, stop_q;
  logic [31:0]        rd_blk_q, wr_blk_q, blk_q;
  logic [BRAM_AW-1:0] idx_q, idx_d;
  logic [TW-1:0]      tmo_q;
  logic               err_range_q, err_timeout_q, rd_done_q, wr_done_q;

  logic        in_burst, burst_last, blk_last, stop_now;
  logic [31:0] chk_blk, blk_off;

  assign in_burst   = (state_q == S_BURST);
  assign burst_last = ((idx_q & BL_MASK) == BL_MASK);
  assign blk_last   = (idx_q == LAST_IX);
  assign stop_now   = stop_q | (rd_stop & ~sel_wr_q);
  assign chk_blk    = sel_wr_q ? wr_blk_q : rd_blk_q;
  assign blk_off    = blk_q << (BRAM_AW + 2);
  assign idx_d      = idx_q + BRAM_AW'(1);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rd_pend_q     <= 1'b0;
      wr_pend_q     <= 1'b0;
      sel_wr_q      <= 1'b0;
      stop_q        <= 1'b0;
      rd_blk_q      <= '0;
      wr_blk_q      <= '0;
      blk_q         <= '0;
      idx_q         <= '0;
      tmo_q         <= '0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      rd_done_q     <= 1'b0;
      wr_done_q     <= 1'b0;
    end else begin
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // IDLE reacts to the live request pulse as well as the latch, so a read strobes two cycles after its request
          if (wr_pend_q || wr_req) begin
            sel_wr_q <= 1'b1;
            state_q  <= S_CHECK;
          end else if (rd_pend_q || rd_req) begin
            sel_wr_q <= 1'b0;
            state_q  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (sel_wr_q) wr_pend_q <= 1'b0;
          else          rd_pend_q <= 1'b0;
          err_range_q   <= 1'b0;
          err_timeout_q <= 1'b0;
          idx_q         <= '0;
          tmo_q         <= '0;
          stop_q        <= 1'b0;
          blk_q         <= chk_blk;
          if (chk_blk >= CAP_BLOCKS) begin
            err_range_q <= 1'b1;
            state_q     <= S_FINISH;
          end else begin
            state_q <= sel_wr_q ? S_WR_PRIME : S_BURST;
          end
        end
        S_WR_PRIME: state_q <= S_BURST;
        S_BURST: begin
          if (rd_stop && !sel_wr_q) stop_q <= 1'b1;
          if (wbm_ack_i) begin
            idx_q <= idx_d;
            tmo_q <= '0;
            if (burst_last) state_q <= (blk_last || stop_now) ? S_FINISH : S_GAP;
          end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_GAP: begin
          if (rd_stop && !sel_wr_q) stop_q <= 1'b1;
          tmo_q   <= '0;
          state_q <= stop_now ? S_FINISH : S_BURST;
        end
        S_FINISH: begin
          rd_done_q <= ~sel_wr_q;
          wr_done_q <= sel_wr_q;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // New requests are applied last so they win over the clear in CHECK
      if (rd_req) begin
        rd_pend_q <= 1'b1;
        rd_blk_q  <= rd_blk;
      end
      if (wr_req) begin
        wr_pend_q <= 1'b1;
        wr_blk_q  <= wr_blk;
      end
    end
  end

  assign rd_done     = rd_done_q;
  assign wr_done     = wr_done_q;
  assign err_range   = err_range_q;
  assign err_timeout = err_timeout_q;
  assign busy        = (state_q != S_IDLE) | rd_pend_q | wr_pend_q;

  assign wbm_cyc_o = in_burst;
  assign wbm_stb_o = in_burst;
  assign wbm_we_o  = in_burst & sel_wr_q;
  assign wbm_sel_o = in_burst ? 4'hF : 4'h0;
  assign wbm_bte_o = '0;
  assign wbm_cti_o = (!in_burst || BURST_LEN == 1) ? 3'b000 :
                     (burst_last ? 3'b111 : 3'b010);
  assign wbm_adr_o = in_burst ? (BASE_ADDR + blk_off + {{(30 - BRAM_AW){1'b0}}, idx_q, 2'b00}) : '0;
  assign wbm_dat_o = (in_burst & sel_wr_q) ? bram_wr_q : '0;

  assign bram_rd_wren = in_burst & ~sel_wr_q & wbm_ack_i;
  assign bram_rd_addr = idx_q;
  assign bram_rd_data = bram_rd_wren ? wbm_dat_i : '0;

  // Address one word ahead on an accepted write beat so the BRAM output tracks the next beat with zero-wait acks
  assign bram_wr_addr = (in_burst & sel_wr_q & wbm_ack_i) ? idx_d : idx_q;

endmodule

// File: tb/tb_sd_wb_block_dma.sv
// Bench for sd_wb_block_dma: Wishbone slave memory, two BRAM models and an
// operation-level reference model checked every cycle, plus directed scenarios.
module tb_sd_wb_block_dma;

  localparam int          BW   = 128;
  localparam int          L    = 8;
  localparam int          TMO  = 1023;
  localparam logic [31:0] CAP  = 32'd127488;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n, rd_req, rd_stop, wr_req;
  logic [31:0] rd_blk, wr_blk;
  logic        rd_done, wr_done, busy, err_range, err_timeout;
  logic [6:0]  bram_rd_addr, bram_wr_addr;
  logic        bram_rd_wren;
  logic [31:0] bram_rd_data;
  logic [31:0] bram_wr_q = '0;
  logic [31:0] wbm_adr_o, wbm_dat_i, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;

  sd_wb_block_dma #(
    .BLK_WORDS(128), .BRAM_AW(7), .BURST_LEN(8),
    .BASE_ADDR(32'h0000_0000), .CAP_BLOCKS(32'd127488), .ACK_TIMEOUT(1023)
  ) dut (
    .clk_50(clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_blk(rd_blk), .rd_stop(rd_stop), .rd_done(rd_done),
    .wr_req(wr_req), .wr_blk(wr_blk), .wr_done(wr_done),
    .busy(busy), .err_range(err_range), .err_timeout(err_timeout),
    .bram_rd_addr(bram_rd_addr), .bram_rd_wren(bram_rd_wren), .bram_rd_data(bram_rd_data),
    .bram_wr_addr(bram_wr_addr), .bram_wr_q(bram_wr_q),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_ack_i(wbm_ack_i), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o)
  );

  always #10 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic [31:0] mem     [0:4095];
  logic [31:0] wr_bram [0:BW-1];
  logic [31:0] rd_bram [0:BW-1];

  always @(posedge clk) begin
    if (bram_rd_wren) rd_bram[bram_rd_addr] <= bram_rd_data;
    bram_wr_q <= wr_bram[bram_wr_addr];
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
  endtask

  // Wishbone slave: decides ack on the falling edge for the following rising edge
  int waits = 0, stall_at = -1, sl_beats = 0, wcnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_stb_o) begin
        if ((stall_at >= 0 && sl_beats >= stall_at) || wcnt < waits) begin
          wbm_ack_i = 1'b0;
          wcnt++;
        end else begin
          wbm_ack_i = 1'b1;
          wcnt = 0;
          sl_beats++;
          if (wbm_we_o) mem[wbm_adr_o[13:2]] = wbm_dat_o;
          else          wbm_dat_i = mem[wbm_adr_o[13:2]];
        end
      end else begin
        wbm_ack_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Reference model: queue of operations in the order the engine must service them
  typedef struct {
    bit we;
    int blk;
    int exp_beats;
    bit exp_rng;
    bit exp_tmo;
  } op_t;
  op_t ops[$];

  int          beats = 0, idle_run = 0, nack_run = 0, last_done_cyc = 0, last_stb_cyc = 0, n_last_cti = 0;
  bit          prev_stb = 0, prev_ack = 0;
  logic [31:0] first_adr = '0, last_adr = '0;

  initial begin
    op_t         cur;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_stb = 0; prev_ack = 0; nack_run = 0; idle_run = 0;
      end else begin
        if (wbm_stb_o) begin
          if (ops.size() == 0) begin
            chk("stb_without_request", wbm_stb_o, 1'b0);
          end else begin
            cur = ops[0];
            if (!prev_stb && beats > 0) chk("gap_len", idle_run, 1);
            ea = BASE + 32'(cur.blk) * 32'd512 + 32'(beats) * 32'd4;
            chk("adr", wbm_adr_o, ea);
            chk("we", wbm_we_o, cur.we);
            chk("cyc", wbm_cyc_o, 1'b1);
            chk("cti", wbm_cti_o, (beats % L == L - 1) ? 3'b111 : 3'b010);
            chk("sel_bte", {wbm_sel_o, wbm_bte_o}, 6'b111100);
            if (cur.we && beats < BW) chk("dat_o", wbm_dat_o, wr_bram[beats]);
            chk("rd_wren", bram_rd_wren, wbm_ack_i && !cur.we);
            if (wbm_ack_i) begin
              chk("beat_limit", beats < cur.exp_beats, 1'b1);
              if (!cur.we) begin
                chk("rd_addr", bram_rd_addr, beats[6:0]);
                chk("rd_data", bram_rd_data, wbm_dat_i);
              end
              if (beats == 0) begin first_adr = wbm_adr_o; n_last_cti = 0; end
              if (wbm_cti_o == 3'b111) n_last_cti++;
              last_adr = wbm_adr_o;
              beats++;
              nack_run = 0;
            end else begin
              nack_run++;
            end
          end
          last_stb_cyc = cyc_cnt;
          idle_run = 0;
        end else begin
          if (prev_stb && !prev_ack) chk("timeout_len", nack_run, TMO);
          chk("idle_bus", {wbm_cyc_o, bram_rd_wren}, 2'b00);
          nack_run = 0;
          idle_run++;
        end
        if (rd_done || wr_done) begin
          if (ops.size() == 0) begin
            chk("done_without_request", {rd_done, wr_done}, 2'b00);
          end else begin
            cur = ops.pop_front();
            chk("done_dir", {rd_done, wr_done}, cur.we ? 2'b01 : 2'b10);
            chk("done_beats", beats, cur.exp_beats);
            chk("done_err", {err_range, err_timeout}, {cur.exp_rng, cur.exp_tmo});
            if (cur.exp_beats > 0) chk("done_latency", cyc_cnt - last_stb_cyc, 2);
            last_done_cyc = cyc_cnt;
            beats = 0;
          end
        end
        prev_stb = wbm_stb_o;
        prev_ack = wbm_ack_i;
      end
    end
  end

  int req_cyc = 0;

  task automatic push_op(input bit we, input int blk, input int nb, input bit rng, input bit tmo);
    op_t o;
    o.we = we; o.blk = blk; o.exp_beats = nb; o.exp_rng = rng; o.exp_tmo = tmo;
    ops.push_back(o);
  endtask

  task automatic issue(input bit do_rd, input int rblk, input bit do_wr, input int wblk);
    @(posedge clk); #1;
    rd_req = do_rd; rd_blk = rblk;
    wr_req = do_wr; wr_blk = wblk;
    req_cyc = cyc_cnt;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (ops.size() != 0 && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    chk(nm, ops.size(), 0);
  endtask

  function automatic int rd_mismatch(input int blk);
    int m = 0;
    for (int i = 0; i < BW; i++) if (rd_bram[i] !== mem[blk * BW + i]) m++;
    return m;
  endfunction

  function automatic int wr_mismatch(input int blk);
    int m = 0;
    for (int i = 0; i < BW; i++) if (mem[blk * BW + i] !== wr_bram[i]) m++;
    return m;
  endfunction

  initial begin
    int n;
    int low;
    reset_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; rd_stop = 1'b0;
    rd_blk = '0; wr_blk = '0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    for (int i = 0; i < 4096; i++) mem[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    for (int i = 0; i < BW; i++) begin
      wr_bram[i] = 32'hB000_0000 + 32'(i) * 32'd3 + 32'd1;
      rd_bram[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus_outputs",
        {wbm_adr_o, wbm_dat_o, bram_rd_data, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
         wbm_cti_o, wbm_bte_o, bram_rd_addr, bram_rd_wren, bram_wr_addr}, '0);
    chk("reset_status", {busy, err_range, err_timeout, rd_done, wr_done}, 5'b0);
    reset_n = 1'b1;

    // Read block 3, zero-wait slave
    waits = 0;
    push_op(1'b0, 3, BW, 1'b0, 1'b0);
    issue(1'b1, 3, 1'b0, 0);
    wait_done(400, "t1_complete");
    chk("t1_done_cycle", last_done_cyc - req_cyc, 146);
    chk("t1_first_adr", first_adr, 32'h0000_0600);
    chk("t1_last_adr", last_adr, 32'h0000_07FC);
    chk("t1_bursts", n_last_cti, 16);
    chk("t1_bram_contents", rd_mismatch(3), 0);

    // Write block 0, two wait states per beat
    waits = 2;
    push_op(1'b1, 0, BW, 1'b0, 1'b0);
    issue(1'b0, 0, 1'b1, 0);
    wait_done(800, "t2_complete");
    chk("t2_done_cycle", last_done_cyc - req_cyc, 403);
    chk("t2_mem_contents", wr_mismatch(0), 0);

    // Simultaneous requests: write serviced first, busy held throughout
    waits = 0;
    push_op(1'b1, 5, BW, 1'b0, 1'b0);
    push_op(1'b0, 6, BW, 1'b0, 1'b0);
    issue(1'b1, 6, 1'b1, 5);
    low = 0;
    n = 0;
    while (ops.size() != 0 && n < 800) begin
      @(negedge clk); #2;
      n++;
      if (ops.size() != 0 && !busy) low++;
    end
    chk("t3_complete", ops.size(), 0);
    chk("t3_busy_low_cycles", low, 0);
    chk("t3_mem_contents", wr_mismatch(5), 0);
    chk("t3_bram_contents", rd_mismatch(6), 0);

    // Out-of-range write: no bus cycle, error flagged
    push_op(1'b1, int'(CAP), 0, 1'b1, 1'b0);
    issue(1'b0, 0, 1'b1, int'(CAP));
    wait_done(20, "t4_complete");
    chk("t4_done_cycle", last_done_cyc - req_cyc, 3);
    chk("t4_err_range", err_range, 1'b1);

    // Slave stops acking at beat 20
    stall_at = 20;
    sl_beats = 0;
    push_op(1'b0, 1, 20, 1'b0, 1'b1);
    issue(1'b1, 1, 1'b0, 0);
    wait_done(1500, "t5_complete");
    chk("t5_err_timeout", err_timeout, 1'b1);
    stall_at = -1;
    push_op(1'b0, 2, BW, 1'b0, 1'b0);
    issue(1'b1, 2, 1'b0, 0);
    wait_done(400, "t5b_complete");
    chk("t5_err_cleared", {err_range, err_timeout}, 2'b00);

    // rd_stop raised during burst 2
    push_op(1'b0, 4, 24, 1'b0, 1'b0);
    issue(1'b1, 4, 1'b0, 0);
    n = 0;
    while (beats < 18 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    chk("t6_reached_burst2", beats >= 18, 1'b1);
    @(posedge clk); #1; rd_stop = 1'b1;
    @(posedge clk); #1; rd_stop = 1'b0;
    wait_done(100, "t6_complete");
    repeat (20) @(posedge clk);
    chk("t6_errs", {err_range, err_timeout}, 2'b00);

    // Reset asserted mid-burst
    push_op(1'b0, 7, BW, 1'b0, 1'b0);
    issue(1'b1, 7, 1'b0, 0);
    n = 0;
    while (beats < 10 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("t7_reset_bus_outputs",
        {wbm_adr_o, wbm_dat_o, bram_rd_data, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
         wbm_cti_o, wbm_bte_o, bram_rd_addr, bram_rd_wren, bram_wr_addr}, '0);
    chk("t7_reset_status", {busy, err_range, err_timeout, rd_done, wr_done}, 5'b0);
    ops.delete();
    beats = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    push_op(1'b0, 8, BW, 1'b0, 1'b0);
    issue(1'b1, 8, 1'b0, 0);
    wait_done(400, "t7_recovery");
    chk("t7_bram_contents", rd_mismatch(8), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sd_wb_block_dma.md
Name: sd_wb_block_dma

Overview:
Parametrised block-transfer engine between the SD block buffers and Wishbone memory. It is the successor to the fixed single-beat external transfer path.
- Read request: fetches one block from Wishbone memory into the read-buffer BRAM.
- Write request: drains one block from the write-buffer BRAM to Wishbone memory.
- Adds incrementing bursts, a configurable storage window, capacity range checking, ack timeout, and queuing of one pending request per direction.
- Sits between sd_mgr (request/done handshake, BRAM ports) and the system Wishbone fabric.

Parameters:
- BLK_WORDS, 128: 32-bit words per block; power of 2.
- BRAM_AW, 7: BRAM word address width; equals log2(BLK_WORDS).
- BURST_LEN, 8: words per Wishbone burst; power of 2, divides BLK_WORDS, value 1 gives single-beat classic cycles.
- BASE_ADDR, 32'h0000_0000: byte address of block 0 in Wishbone space.
- CAP_BLOCKS, 32'd127488: number of valid blocks; block numbers >= CAP_BLOCKS are out of range.
- ACK_TIMEOUT, 1023: maximum cycles stb may wait for ack.

Ports:
- clk_50  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- rd_req  in  1  one-cycle pulse: fetch block rd_blk into the read BRAM.
- rd_blk  in  32  block number, sampled on rd_req.
- rd_stop  in  1  abort the read in progress.
- rd_done  out  1  one-cycle completion pulse for a read (success, abort or error).
- wr_req  in  1  one-cycle pulse: store the write BRAM to block wr_blk.
- wr_blk  in  32  block number, sampled on wr_req.
- wr_done  out  1  one-cycle completion pulse for a write.
- busy  out  1  high while not IDLE or while any request is pending.
- err_range  out  1  sticky: last completed operation was out of range.
- err_timeout  out  1  sticky: last completed operation hit an ack timeout.
- bram_rd_addr  out  BRAM_AW  read-buffer write address.
- bram_rd_wren  out  1  read-buffer write enable.
- bram_rd_data  out  32  read-buffer write data.
- bram_wr_addr  out  BRAM_AW  write-buffer read address; BRAM has 1-cycle read latency.
- bram_wr_q  in  32  write-buffer read data.
- wbm_adr_o  out  32  byte address.
- wbm_dat_i  in  32  read data.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte select; always 4'hF during a cycle.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_ack_i  in  1  acknowledge.
- wbm_cti_o  out  3  cycle type identifier.
- wbm_bte_o  out  2  burst type extension; constant 2'b00.

Behaviour:
- Reset: all outputs 0, including wbm_cti_o=3'b000, err flags and pending latches; state IDLE. Asserting reset mid-burst drops cyc/stb asynchronously; no done pulse is generated.
- Pending latches:
  - rd_req/wr_req set a pending bit and capture the block number in any state.
  - A repeat request while its own bit is already pending overwrites the block number.
- States: IDLE, CHECK, WR_PRIME, BURST, GAP, FINISH.
- IDLE: if write pending, go to CHECK with write selected; otherwise if read pending, go to CHECK with read. Write has priority when both are pending.
- CHECK:
  - Clear the pending bit of the selected direction, clear both err flags, word index = 0.
  - If blk >= CAP_BLOCKS: set err_range and go to FINISH. No bus activity.
  - Otherwise go to WR_PRIME for a write, BURST for a read.
- Address: wbm_adr_o = BASE_ADDR + blk*BLK_WORDS*4 + index*4, computed modulo 2^32.
- WR_PRIME: drive bram_wr_addr = index; exactly one cycle, then BURST.
- BURST:
  - cyc=stb=1; we=1 for a write, 0 for a read.
  - cti=3'b010, except the final beat of each burst, which uses 3'b111. When BURST_LEN=1, cti=3'b000.
  - On each ack: index increments, and the next beat is presented in the next cycle.
  - Read path: on each ack, bram_rd_wren=1, bram_rd_addr=index, bram_rd_data=wbm_dat_i in the same cycle.
  - Write path: wbm_dat_o must equal the BRAM word at index for every accepted beat. Prefetch so that zero-wait acks sustain 1 word/cycle.
  - After the last beat of a burst: go to GAP if words remain, otherwise FINISH.
- GAP: cyc=stb=0 for exactly one cycle, then BURST. For writes, bram_wr_addr is re-primed during this cycle.
- Ack timeout: counter clears on every ack and on burst start. If it reaches ACK_TIMEOUT while stb=1: drop cyc/stb, set err_timeout, go to FINISH.
- rd_stop (reads only): sampled in BURST or GAP. The current burst completes normally; then go to FINISH without further bursts. No error flag is set.
- FINISH: one-cycle rd_done or wr_done pulse for the serviced direction, then IDLE. Done and the next CHECK are never in the same cycle.
- Request pulse in the same cycle as FINISH: latched, and serviced after IDLE.
- Latency: request pulse at cycle N gives the first stb at N+2 (read) or N+3 (write). With zero-wait acks, a full block takes BLK_WORDS + BLK_WORDS/BURST_LEN - 1 bus cycles.

Test Plan:
- Read, blk=3, defaults, slave acks every stb cycle -> 16 bursts of 8 beats; addresses from 0x600 to 0x7FC; cti 010×7 then 111; one-cycle gaps; BRAM words 0..127 equal the memory contents; rd_done at the expected cycle; no errors.
- Write, blk=0, slave inserts 2 wait states per beat -> memory 0x000–0x1FC equals BRAM contents in order; wbm_dat_o stable while stb is high and ack is low; one wr_done pulse.
- rd_req and wr_req in the same cycle -> write completes first (wr_done), then read (rd_done); busy stays high throughout.
- wr_blk=CAP_BLOCKS -> cyc never asserted; err_range=1; wr_done pulses 3 cycles after the request.
- Slave stops acking at beat 20 -> cyc/stb drop after 1023 cycles; err_timeout=1; rd_done pulses; the next read clears err_timeout.
- rd_stop during burst 2 -> bursts 0–2 complete, no further cyc; rd_done pulses; err flags stay 0. Reset asserted mid-burst -> all outputs 0 immediately.
